// File: rtl/regex_cpu_multi.sv
// regex_cpu_multi: one-thread-in-flight regex execution unit (fetch, execute, emit 0..2 successors).
// Define REGEX_CPU_PERF_COUNTERS_EN to add saturating instr_count / accept_count outputs.
module regex_cpu_multi #(
   parameter int PC_WIDTH          = 8,
   parameter int CC_ID_BITS        = 2,
   parameter int CHARACTER_WIDTH   = 8,
   parameter int MEMORY_WIDTH      = 16,
   parameter int MEMORY_ADDR_WIDTH = 11
) (
   input  logic                                            clk,
   input  logic                                            rst,
`ifdef REGEX_CPU_PERF_COUNTERS_EN
   output logic [31:0]                                     instr_count,
   output logic [31:0]                                     accept_count,
`endif
   input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]      current_characters,
   input  logic [2**CC_ID_BITS-1:0]                        end_of_string,
   input  logic                                            input_pc_valid,
   input  logic [PC_WIDTH-1:0]                             input_pc,
   input  logic [CC_ID_BITS-1:0]                           input_cc_id,
   output logic                                            input_pc_ready,
   output logic                                            memory_valid,
   output logic [MEMORY_ADDR_WIDTH-1:0]                    memory_addr,
   input  logic                                            memory_ready,
   input  logic [MEMORY_WIDTH-1:0]                         memory_data,
   output logic                                            output_pc_valid,
   output logic [PC_WIDTH-1:0]                             output_pc,
   output logic [CC_ID_BITS-1:0]                           output_cc_id,
   input  logic                                            output_pc_ready,
   output logic                                            accepts
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_OUT_A, S_OUT_B} state_t;

   localparam logic [2:0] OP_ACCEPT     = 3'b000;
   localparam logic [2:0] OP_SPLIT      = 3'b001;
   localparam logic [2:0] OP_MATCH      = 3'b010;
   localparam logic [2:0] OP_JMP        = 3'b011;
   localparam logic [2:0] OP_MATCH_ANY  = 3'b101;
   localparam logic [2:0] OP_ACCEPT_P   = 3'b110;
   localparam logic [2:0] OP_NOT_MATCH  = 3'b111;

   state_t                    state_q, state_d;
   logic [PC_WIDTH-1:0]       pc_q, a_pc_q, b_pc_q;
   logic [CC_ID_BITS-1:0]     cc_q, a_cc_q;
   logic [MEMORY_WIDTH-1:0]   ir_q;
   logic                      split_q, accepts_q;

   logic [2:0]                op;
   logic [MEMORY_WIDTH-4:0]   dat;
   logic [CHARACTER_WIDTH-1:0] ch;
   logic                      eos, ex_a_vld, ex_split, ex_acc;
   logic [PC_WIDTH-1:0]       ex_a_pc;
   logic [CC_ID_BITS-1:0]     ex_a_cc;

   // Instruction decode; only meaningful while in EXEC.
   always_comb begin
      op       = ir_q[MEMORY_WIDTH-1:MEMORY_WIDTH-3];
      dat      = ir_q[MEMORY_WIDTH-4:0];
      ch       = current_characters[int'(cc_q)*CHARACTER_WIDTH +: CHARACTER_WIDTH];
      eos      = end_of_string[cc_q];
      ex_a_vld = 1'b0;
      ex_split = 1'b0;
      ex_acc   = 1'b0;
      ex_a_pc  = pc_q + PC_WIDTH'(1);
      ex_a_cc  = cc_q;
      case (op)
         OP_ACCEPT:    ex_acc = eos;
         OP_SPLIT:     begin ex_a_vld = 1'b1; ex_split = 1'b1; end
         OP_MATCH:     if (!eos && ch == dat[CHARACTER_WIDTH-1:0]) begin
                          ex_a_vld = 1'b1;
                          ex_a_cc  = cc_q + CC_ID_BITS'(1);
                       end
         OP_JMP:       begin ex_a_vld = 1'b1; ex_a_pc = dat[PC_WIDTH-1:0]; end
         OP_MATCH_ANY: if (!eos) begin
                          ex_a_vld = 1'b1;
                          ex_a_cc  = cc_q + CC_ID_BITS'(1);
                       end
         OP_ACCEPT_P:  ex_acc = 1'b1;
         OP_NOT_MATCH: ex_a_vld = !eos && ch != dat[CHARACTER_WIDTH-1:0];
         default:      ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (input_pc_valid) state_d = S_FETCH;
         S_FETCH: if (memory_ready) state_d = S_WAIT;
         S_WAIT:  state_d = S_EXEC;
         S_EXEC:  state_d = ex_a_vld ? S_OUT_A : S_IDLE;
         S_OUT_A: if (output_pc_ready) state_d = split_q ? S_OUT_B : S_IDLE;
         S_OUT_B: if (output_pc_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= '0;
         cc_q      <= '0;
         ir_q      <= '0;
         a_pc_q    <= '0;
         a_cc_q    <= '0;
         b_pc_q    <= '0;
         split_q   <= 1'b0;
         accepts_q <= 1'b0;
      end else begin
         accepts_q <= (state_q == S_EXEC) && ex_acc;
         if (state_q == S_IDLE && input_pc_valid) begin
            pc_q <= input_pc;
            cc_q <= input_cc_id;
         end
         if (state_q == S_WAIT) ir_q <= memory_data;
         if (state_q == S_EXEC) begin
            a_pc_q  <= ex_a_pc;
            a_cc_q  <= ex_a_cc;
            b_pc_q  <= dat[PC_WIDTH-1:0];
            split_q <= ex_split;
         end
      end
   end

   // Outputs are forced low while rst is high, whatever state is still registered.
   always_comb begin
      input_pc_ready  = !rst && state_q == S_IDLE;
      memory_valid    = !rst && state_q == S_FETCH;
      memory_addr     = rst ? '0 : MEMORY_ADDR_WIDTH'(pc_q);
      output_pc_valid = !rst && (state_q == S_OUT_A || state_q == S_OUT_B);
      output_pc       = '0;
      output_cc_id    = '0;
      if (output_pc_valid) begin
         output_pc    = (state_q == S_OUT_B) ? b_pc_q : a_pc_q;
         output_cc_id = a_cc_q;
      end
      accepts         = !rst && accepts_q;
   end

`ifdef REGEX_CPU_PERF_COUNTERS_EN
   logic [31:0] instr_count_q, accept_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_count_q  <= '0;
         accept_count_q <= '0;
      end else begin
         if (state_q == S_EXEC && instr_count_q != '1) instr_count_q <= instr_count_q + 32'd1;
         if (accepts_q && accept_count_q != '1) accept_count_q <= accept_count_q + 32'd1;
      end
   end

   assign instr_count  = instr_count_q;
   assign accept_count = accept_count_q;
`endif

endmodule
